sign_val_10: RTL

- Inverse of the magnitude stage: rebuilds a signed two's-complement value from a 10-bit magnitude plus a sign flag.
- Used on the reconstruction path: a range or angle magnitude and a direction bit come back from the ultrasound/IR side and become a signed coordinate for the locator math.
- Streaming ready/valid block with a one-register compute stage and a small output FIFO, so downstream stalls do not drop samples.

---
 rtl/phone_home_pkg.sv | 8 +
 rtl/sync_fifo_small.sv | 52 +++++
 rtl/sign_val_10.sv | 71 +++++++
 3 files changed

// File: rtl/phone_home_pkg.sv
// phone_home_pkg: shared widths, sign encoding and sizing helper for the locator datapath
package phone_home_pkg;
    localparam int MAG_WIDTH_DEFAULT = 10;
    localparam logic SIGN_NEG = 1'b1;
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/sync_fifo_small.sv
// sync_fifo_small: small circular-buffer FIFO with registered storage and occupancy count
module sync_fifo_small
    import phone_home_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int DEPTH = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            din_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            head_o,
    output logic [cnt_width(DEPTH)-1:0] count_o,
    output logic                        full_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_width(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop, empty;

    always_comb begin
        empty    = (count_q == '0);
        full_o   = (count_q == FULL);
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty;
        wr_ptr_d = do_push ? ((wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = do_pop ? ((rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d  = (do_push && !do_pop) ? count_q + 1'b1 :
                   (!do_push && do_pop) ? count_q - 1'b1 : count_q;
        head_o   = empty ? '0 : mem_q[rd_ptr_q];
        count_o  = count_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/sign_val_10.sv
// sign_val_10: rebuilds a signed two's-complement value from magnitude plus sign, streamed through a compute register and output FIFO
module sign_val_10
    import phone_home_pkg::*;
#(
    parameter int MAG_WIDTH = MAG_WIDTH_DEFAULT,
    parameter int DEPTH     = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MAG_WIDTH-1:0] in_mag,
    input  logic                 in_neg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MAG_WIDTH:0]   out_val,
    output logic                 neg_zero
);
    localparam int CW = cnt_width(DEPTH);

    function automatic logic [MAG_WIDTH:0] apply_sign(input logic [MAG_WIDTH-1:0] mag, input logic neg);
        logic [MAG_WIDTH:0] x;
        x = {1'b0, mag};
        return (neg == SIGN_NEG) ? (~x) + 1'b1 : x;
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    logic [MAG_WIDTH:0]   s1_val_q, s1_val_d;
    logic                 neg_zero_q, neg_zero_d;
    logic                 accept, push, pop, fifo_full;
    logic [CW-1:0]        fifo_count;

    // in_ready looks only at registered state so out_ready never reaches it combinationally
    always_comb begin
        in_ready   = !s1_valid_q || !fifo_full;
        accept     = in_valid && in_ready;
        push       = s1_valid_q && !fifo_full;
        out_valid  = (fifo_count != '0);
        pop        = out_valid && out_ready;
        s1_valid_d = accept ? 1'b1 : (push ? 1'b0 : s1_valid_q);
        s1_val_d   = accept ? apply_sign(in_mag, in_neg) : s1_val_q;
        neg_zero_d = neg_zero_q || (accept && in_neg == SIGN_NEG && in_mag == '0);
        neg_zero   = neg_zero_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_val_q   <= '0;
            neg_zero_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_val_q   <= s1_val_d;
            neg_zero_q <= neg_zero_d;
        end
    end

    sync_fifo_small #(
        .WIDTH(MAG_WIDTH + 1),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i  (clock),
        .rst_i  (reset),
        .push_i (push),
        .din_i  (s1_val_q),
        .pop_i  (pop),
        .head_o (out_val),
        .count_o(fifo_count),
        .full_o (fifo_full)
    );
endmodule
